// File: rtl/instruction_fetch_unit_pkg.sv
// Shared MIPS definitions for the fetch stage: opcode field values,
// fetch FSM state encoding and the default reset PC.
package mips_defs;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ready handshake, the
// valid/ready handoff to decode/execute, and decode feedback for next PC.
// master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [5:0]        function_code;
  logic [ADDR_W-1:0] pc_out;
  logic              beq;
  logic              zero;
  logic              jmp;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, function_code, pc_out,
    input  imem_ready, imem_rdata, instr_ready, beq, zero, jmp
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, function_code, pc_out,
    output imem_ready, imem_rdata, instr_ready, beq, zero, jmp
  );
endinterface

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: sequential (pc+4), taken beq
// (pc+4 + sign-extended word offset) or jmp (pseudo-direct target).
// Jump has priority over branch; result is always word aligned.
module next_pc_logic #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              beq,
  input  logic              zero,
  input  logic              jmp,
  output logic [ADDR_W-1:0] next_pc
);
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] sel_pc;

  assign pc4         = pc + ADDR_W'(4);
  assign branch_off  = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign jump_target = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};

  // Redirect mux; low two bits cleared so the PC can never go misaligned
  always_comb begin
    sel_pc = pc4;
    if (jmp)
      sel_pc = jump_target;
    else if (beq && zero)
      sel_pc = pc4 + branch_off;
    next_pc = {sel_pc[ADDR_W-1:2], 2'b00};
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory and
// presents them to decode/execute; the PC advances only when execute
// accepts. Optional performance counters are built when
// FETCH_PERF_CNT_EN is defined; otherwise the counter outputs read 0.
module instruction_fetch_unit
  import mips_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   fetch_if,
  output logic [31:0]                fetch_count,
  output logic [31:0]                taken_count
);
  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       instr_reg;
  logic              imem_req_reg;
  logic              instr_valid_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              accept;

  // Execute takes the presented instruction this cycle
  assign accept = (state_reg == ST_HOLD) && fetch_if.instr_ready;

  next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc      (pc_reg),
    .instr   (instr_reg),
    .beq     (fetch_if.beq),
    .zero    (fetch_if.zero),
    .jmp     (fetch_if.jmp),
    .next_pc (pc_next)
  );

  // Fetch FSM with registered request/valid outputs, PC and instruction latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg    <= ST_FETCH;
          imem_req_reg <= 1'b1;
        end
        ST_FETCH: begin
          if (fetch_if.imem_ready) begin
            instr_reg       <= fetch_if.imem_rdata;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b1;
            state_reg       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (fetch_if.instr_ready) begin
            pc_reg          <= pc_next;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= ST_FETCH;
          end
        end
        default: begin
          state_reg       <= ST_IDLE;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_if.imem_req      = imem_req_reg;
  assign fetch_if.imem_addr     = pc_reg;
  assign fetch_if.instr_valid   = instr_valid_reg;
  assign fetch_if.instr         = instr_reg;
  assign fetch_if.opcode        = instr_reg[31:26];
  assign fetch_if.function_code = instr_reg[5:0];
  assign fetch_if.pc_out        = pc_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] taken_count_reg;

  // Count accepted instructions and the redirects they caused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_reg <= '0;
      taken_count_reg <= '0;
    end else if (accept) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
      if (fetch_if.jmp || (fetch_if.beq && fetch_if.zero))
        taken_count_reg <= taken_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign taken_count = taken_count_reg;
`else
  assign fetch_count = '0;
  assign taken_count = '0;
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: an instruction-memory
// responder pushes the expected {instr, pc} into a scoreboard, which is
// popped when the DUT presents instr_valid. Counter expectations follow
// FETCH_PERF_CNT_EN.
module tb_instruction_fetch_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_count;
  logic [31:0] taken_count;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_W(32)) bus ();

  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_if    (bus),
    .fetch_count (fetch_count),
    .taken_count (taken_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_valid_cyc = -1;
  logic [31:0] model_pc;
  logic [31:0] fetch_m;
  logic [31:0] taken_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic b, input logic z, input logic j);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (j) return {pc4[31:28], ins[25:0], 2'b00};
    if (b && z) return pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    return pc4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef FETCH_PERF_CNT_EN
    check_val({tag, "_fetch_count"}, fetch_count, fetch_m);
    check_val({tag, "_taken_count"}, taken_count, taken_m);
`else
    check_val({tag, "_fetch_count"}, fetch_count, 32'd0);
    check_val({tag, "_taken_count"}, taken_count, 32'd0);
`endif
  endtask

  // One complete transaction: memory responds after rdy_dly cycles,
  // execute accepts after acc_dly cycles with the given decode feedback.
  task automatic do_fetch(input int rdy_dly, input logic [31:0] word, input int acc_dly,
                          input logic b, input logic z, input logic j, input bit chk_int);
    int          n;
    exp_t        e;
    logic [31:0] nxt;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_val("req_wait", {31'b0, bus.imem_req}, 32'd1);
    check_val("imem_addr", bus.imem_addr, model_pc);
    // Stall memory; a stray instr_ready+jmp here must be ignored
    for (int i = 0; i < rdy_dly; i++) begin
      bus.imem_ready = 1'b0;
      bus.instr_ready = 1'b1;
      bus.jmp = 1'b1;
      step();
      check_val("stall_req", {31'b0, bus.imem_req}, 32'd1);
      check_val("stall_addr", bus.imem_addr, model_pc);
      check_val("stall_valid", {31'b0, bus.instr_valid}, 32'd0);
    end
    bus.instr_ready = 1'b0;
    bus.jmp = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    sb_q.push_back('{instr: word, pc: model_pc});
    step();
    bus.imem_ready = 1'b0;
    check_val("valid_after_ready", {31'b0, bus.instr_valid}, 32'd1);
    if (chk_int && last_valid_cyc >= 0)
      check_val("issue_interval", cyc - last_valid_cyc, 32'd2);
    last_valid_cyc = cyc;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("instr", bus.instr, e.instr);
      check_val("pc_out", bus.pc_out, e.pc);
      check_val("opcode", {26'b0, bus.opcode}, {26'b0, e.instr[31:26]});
      check_val("function_code", {26'b0, bus.function_code}, {26'b0, e.instr[5:0]});
    end
    // Hold off execute; a stray imem_ready with other data must be ignored
    for (int i = 0; i < acc_dly; i++) begin
      bus.instr_ready = 1'b0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = ~word;
      step();
      check_val("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
      check_val("hold_instr", bus.instr, word);
      check_val("hold_pc", bus.pc_out, model_pc);
    end
    bus.imem_ready = 1'b0;
    nxt = ref_next(model_pc, word, b, z, j);
    bus.instr_ready = 1'b1;
    bus.beq = b;
    bus.zero = z;
    bus.jmp = j;
    step();
    bus.instr_ready = 1'b0;
    bus.beq = 1'b0;
    bus.zero = 1'b0;
    bus.jmp = 1'b0;
    fetch_m = fetch_m + 32'd1;
    if (j || (b && z)) taken_m = taken_m + 32'd1;
    check_val("valid_drop", {31'b0, bus.instr_valid}, 32'd0);
    check_val("refetch_req", {31'b0, bus.imem_req}, 32'd1);
    check_val("next_addr", bus.imem_addr, nxt);
    check_counters("accept");
    $display("txn pc=%h instr=%h beq=%0b zero=%0b jmp=%0b next=%h", model_pc, word, b, z, j, nxt);
    model_pc = nxt;
  endtask

  initial begin
    int n;
    logic [31:0] w;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.beq = 1'b0;
    bus.zero = 1'b0;
    bus.jmp = 1'b0;
    model_pc = 32'h0;
    fetch_m = '0;
    taken_m = '0;

    // Reset state
    repeat (3) step();
    check_val("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check_val("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check_val("rst_instr", bus.instr, 32'd0);
    check_val("rst_pc", bus.pc_out, 32'd0);
    check_counters("rst");
    rst_n = 1'b1;

    // Back-to-back sequential fetches 0,4,8,C
    for (int i = 0; i < 4; i++)
      do_fetch(0, 32'h0022_1820 + i, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // pc=0x10 beq -8, taken, memory 3 cycles late -> 0x0C
    do_fetch(3, {OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    // pc=0x0C same branch not taken -> 0x10
    do_fetch(0, {OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    // pc=0x10 jump to 0x100, execute stalls 5 cycles
    do_fetch(0, {OP_J, 26'h0000040}, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    // pc=0x100 beq with most-negative offset wraps below zero
    do_fetch(1, {OP_BEQ, 5'd3, 5'd3, 16'h8000}, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    // jmp+beq+zero together: jump wins, keeps pc4 upper nibble
    do_fetch(0, {OP_J, 26'h0000040}, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    // jump to the last word, then sequential fetch wraps to 0
    do_fetch(0, {OP_J, 26'h3FF_FFFF}, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_fetch(2, 32'h0000_0020, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset pulse mid-FETCH: request drops at once, late ready ignored
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    rst_n = 1'b0;
    #1;
    check_val("midrst_req", {31'b0, bus.imem_req}, 32'd0);
    check_val("midrst_valid", {31'b0, bus.instr_valid}, 32'd0);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    model_pc = 32'h0;
    fetch_m = '0;
    taken_m = '0;
    sb_q.delete();
    check_val("postrst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check_val("postrst_addr", bus.imem_addr, 32'd0);
    check_counters("postrst");

    // Ten accepts, three of them taken branches (+4 skip)
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) begin
        w = {OP_BEQ, 5'd4, 5'd4, 16'h0001};
        do_fetch(i % 2, w, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
        w = 32'h0100_0024 + i;
        do_fetch(0, w, i % 3, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    check_val("final_fetch_count", fetch_count, 32'd10);
    check_val("final_taken_count", taken_count, 32'd3);
`else
    check_val("final_fetch_count", fetch_count, 32'd0);
    check_val("final_taken_count", taken_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
